// File: rtl/alu_op_sequencer.sv
// Hardwired T0-T5 control sequencer for Rd <= Ra op Rb on the Datapath,
// with GPR preload via MDR, start/done handshake and illegal-op trap.
//
// Ports:
//   clk, clr (async active-low)   clock / reset
//   start                         begin a run (IDLE only)
//   pl_valid/pl_ready/pl_data/pl_reg  preload word handshake
//   instr_in                      instruction presented in T1
//   mdata_out, md_read            Datapath MDataIn side
//   bus_oe, bus_sel               bus source select
//   en_vec                        register enables
//   inc_pc, alu_ctrl              PC increment / ALU op
//   busy, done, err               status
module alu_op_sequencer #(
  parameter int W       = 32,
  parameter int SEL_W   = 5,
  parameter int EN_W    = 32,
  parameter int MAX_PL  = 8,
  parameter int PC_IDX  = 20,
  parameter int MDR_IDX = 21,
  parameter int IR_IDX  = 23,
  parameter int Z_IDX   = 24,
  parameter int MAR_IDX = 25,
  parameter int Y_IDX   = 27,
  parameter int ZLO_IDX = 19
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic [W-1:0]     pl_data,
  input  logic [3:0]       pl_reg,
  input  logic [W-1:0]     instr_in,
  output logic [W-1:0]     mdata_out,
  output logic             md_read,
  output logic             bus_oe,
  output logic [SEL_W-1:0] bus_sel,
  output logic [EN_W-1:0]  en_vec,
  output logic             inc_pc,
  output logic [3:0]       alu_ctrl,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(MAX_PL + 1);

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LA,
    S_LB,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       pl_reg_q;
  // Only the decoded fields [31:15] of the instruction are kept.
  logic [16:0]      ir_q;

  logic [4:0] op;
  logic [3:0] rd;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] alu_dec;
  logic       legal;

  logic             pl_ready_nx;
  logic [W-1:0]     mdata_nx;
  logic             md_read_nx;
  logic             bus_oe_nx;
  logic [SEL_W-1:0] bus_sel_nx;
  logic [EN_W-1:0]  en_nx;
  logic             inc_pc_nx;
  logic [3:0]       alu_nx;
  logic             busy_nx;
  logic             done_nx;

  assign op = ir_q[16:12];
  assign rd = ir_q[11:8];
  assign ra = ir_q[7:4];
  assign rb = ir_q[3:0];

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    alu_dec = 4'd0;
    unique case (1'b1)
      (op == OP_ADD): alu_dec = 4'd1;
      (op == OP_SUB): alu_dec = 4'd2;
      (op == OP_AND): alu_dec = 4'd3;
      (op == OP_OR):  alu_dec = 4'd4;
      default:        alu_dec = 4'd0;
    endcase
  end

  assign legal = (alu_dec != 4'd0);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = pl_valid ? S_LA : S_T0;
      end
      S_LA: state_nx = S_LB;
      S_LB: begin
        if (pl_valid && (cnt_inc < CNT_W'(MAX_PL)))
          state_nx = S_LA;
        else
          state_nx = S_T0;
      end
      S_T0: state_nx = S_T1;
      S_T1: state_nx = S_T2;
      S_T2: state_nx = legal ? S_T3 : S_DONE;
      S_T3: state_nx = S_T4;
      S_T4: state_nx = S_T5;
      S_T5: state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded for the state being entered and registered,
  // so each state's controls are flop outputs for its whole cycle.
  always_comb begin
    pl_ready_nx = 1'b0;
    mdata_nx    = '0;
    md_read_nx  = 1'b0;
    bus_oe_nx   = 1'b0;
    bus_sel_nx  = '0;
    en_nx       = '0;
    inc_pc_nx   = 1'b0;
    alu_nx      = 4'd0;
    done_nx     = 1'b0;
    busy_nx     = (state_nx != S_IDLE);
    unique case (state_nx)
      S_LA: begin
        mdata_nx       = pl_data;
        md_read_nx     = 1'b1;
        en_nx[MDR_IDX] = 1'b1;
      end
      S_LB: begin
        bus_oe_nx       = 1'b1;
        bus_sel_nx      = SEL_W'(MDR_IDX);
        en_nx[pl_reg_q] = 1'b1;
        pl_ready_nx     = 1'b1;
      end
      S_T0: begin
        bus_oe_nx      = 1'b1;
        bus_sel_nx     = SEL_W'(PC_IDX);
        en_nx[MAR_IDX] = 1'b1;
        inc_pc_nx      = 1'b1;
      end
      S_T1: begin
        mdata_nx       = instr_in;
        md_read_nx     = 1'b1;
        en_nx[MDR_IDX] = 1'b1;
      end
      S_T2: begin
        bus_oe_nx     = 1'b1;
        bus_sel_nx    = SEL_W'(MDR_IDX);
        en_nx[IR_IDX] = 1'b1;
      end
      S_T3: begin
        bus_oe_nx    = 1'b1;
        bus_sel_nx   = SEL_W'(ra);
        en_nx[Y_IDX] = 1'b1;
      end
      S_T4: begin
        bus_oe_nx    = 1'b1;
        bus_sel_nx   = SEL_W'(rb);
        en_nx[Z_IDX] = 1'b1;
        alu_nx       = alu_dec;
      end
      S_T5: begin
        bus_oe_nx  = 1'b1;
        bus_sel_nx = SEL_W'(ZLO_IDX);
        en_nx[rd]  = 1'b1;
      end
      S_DONE: done_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pl_reg_q  <= '0;
      ir_q      <= '0;
      pl_ready  <= 1'b0;
      mdata_out <= '0;
      md_read   <= 1'b0;
      bus_oe    <= 1'b0;
      bus_sel   <= '0;
      en_vec    <= '0;
      inc_pc    <= 1'b0;
      alu_ctrl  <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      pl_ready  <= pl_ready_nx;
      mdata_out <= mdata_nx;
      md_read   <= md_read_nx;
      bus_oe    <= bus_oe_nx;
      bus_sel   <= bus_sel_nx;
      en_vec    <= en_nx;
      inc_pc    <= inc_pc_nx;
      alu_ctrl  <= alu_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      if (state == S_IDLE && start) begin
        cnt <= '0;
        err <= 1'b0;
      end
      // Destination GPR travels with the word captured into MDR.
      if (state_nx == S_LA)
        pl_reg_q <= pl_reg;
      if (state == S_LB)
        cnt <= cnt_inc;
      if (state == S_T0)
        ir_q <= instr_in[31:15];
      if (state == S_T2 && !legal)
        err <= 1'b1;
    end
  end

endmodule
